// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a synchronous FIFO and keeps the last byte sent.
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [7:0] last_byte
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            fifo_rd   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            last_byte <= 8'h00;
        end else begin
            fifo_rd <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (!fifo_empty) begin
                        state   <= POP;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
                // The FIFO presents the popped byte one cycle after the read pulse.
                LOAD: begin
                    shift     <= fifo_data;
                    last_byte <= fifo_data;
                    tx        <= 1'b0;
                    cnt       <= '0;
                    state     <= START;
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
                            tx    <= ^last_byte;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + 3'd1;
                            tx    <= shift[0];
                            shift <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        state <= STOP;
                        tx    <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                // tx_done is registered, so it is raised one count early to land in the last cycle.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_PRE_LAST) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised self-checking bench for fifo_uart_tx with a FIFO model and a frame-level reference.
// Honours UART_PARITY_EN to expect the 11-bit frame.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fake_nonempty = 1'b0;
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [7:0] last_byte;
    int         underflows = 0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .last_byte  (last_byte)
    );

    always #5 clk = ~clk;

    // Read side of a synchronous FIFO: data appears the cycle after the pop.
    assign fifo_empty = !fake_nonempty && (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            if (rd_ptr == wr_ptr) underflows <= underflows + 1;
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(b);
    endtask

    // Waits for the pop pulse; returns how many cycles it took (0 on timeout).
    task automatic wait_pop(output int n);
        int k;
        k = 0;
        n = 0;
        while (k < 64) begin
            @(negedge clk);
            k++;
            if (fifo_rd) begin
                n = k;
                break;
            end
            checkOutput("idle_tx", int'(tx), 1);
        end
        if (n == 0) checkOutput("pop_timeout", 0, 1);
    endtask

    // Called at the POP cycle; checks the LOAD cycle and every bit of the frame.
    task automatic check_frame(input logic [7:0] b);
        logic bits [0:NBITS-1];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
`ifdef UART_PARITY_EN
        bits[9] = ^b;
`endif
        bits[NBITS-1] = 1'b1;
        checkOutput("busy_pop", int'(busy), 1);
        checkOutput("tx_pop", int'(tx), 1);
        @(negedge clk);
        checkOutput("rd_one_cycle", int'(fifo_rd), 0);
        checkOutput("tx_load", int'(tx), 1);
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                checkOutput("tx_bit", int'(tx), int'(bits[i]));
                checkOutput("tx_done", int'(tx_done), (i == NBITS-1 && c == CPB-1) ? 1 : 0);
                checkOutput("busy_frame", int'(busy), 1);
                checkOutput("rd_in_frame", int'(fifo_rd), 0);
            end
        end
        checkOutput("last_byte", int'(last_byte), int'(b));
    endtask

    task automatic next_frame(input int exp_wait);
        int n;
        logic [7:0] b;
        wait_pop(n);
        if (n != 0) begin
            checkOutput("pop_latency", n, exp_wait);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pop", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check_frame(b);
            end
        end
    endtask

    task automatic quiet(input int cycles);
        int rd_seen;
        int tx_low;
        int busy_seen;
        rd_seen = 0;
        tx_low = 0;
        busy_seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (fifo_rd) rd_seen++;
            if (!tx) tx_low++;
            if (busy) busy_seen++;
        end
        checkOutput("quiet_rd", rd_seen, 0);
        checkOutput("quiet_tx_low", tx_low, 0);
        checkOutput("quiet_busy", busy_seen, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int k;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", int'(tx), 1);
        checkOutput("rst_rd", int'(fifo_rd), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(tx_done), 0);
        checkOutput("rst_last", int'(last_byte), 0);
        reset = 1'b0;

        quiet(200);

        applyStimulus(8'hA3);
        next_frame(1);
        quiet(10);

        applyStimulus(8'hA3);
        applyStimulus(8'hB6);
        next_frame(1);
        next_frame(2);
        quiet(20);

        // Reset in the middle of data bit 3 of 8'hB6; the byte must not reappear.
        applyStimulus(8'hB6);
        applyStimulus(8'h5C);
        wait_pop(n);
        checkOutput("pop_latency_rst", n, 1);
        void'(exp_q.pop_front());
        repeat (1 + CPB + 3 * CPB + 2) @(negedge clk);
        checkOutput("tx_bit3_before_rst", int'(tx), 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_tx", int'(tx), 1);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_rd", int'(fifo_rd), 0);
        checkOutput("async_last", int'(last_byte), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        next_frame(1);
        quiet(10);

        // fifo_empty wiggles during DATA must not cause a second pop.
        applyStimulus(8'h3C);
        wait_pop(n);
        checkOutput("pop_latency_toggle", n, 1);
        fork
            check_frame(exp_q.pop_front());
            begin
                repeat (10) @(negedge clk);
                repeat (16) begin
                    fake_nonempty = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                fake_nonempty = 1'b0;
            end
        join
        quiet(10);

        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) applyStimulus(8'($urandom));
            next_frame(1);
            for (int j = 1; j < k; j++) next_frame(2);
            quiet($urandom_range(2, 8));
        end

        checkOutput("underflow", underflows, 0);
        checkOutput("all_popped", int'(rd_ptr), int'(wr_ptr));
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
